led_frame_loader: RTL
=====================

// Module: led_frame_loader
// PURPOSE
//  Upstream feeder for led_shifter. Assembles a framed byte stream (from the MCU SPI receiver)
//  into a double-buffered N_LEDS x 24-bit colour frame and drives led_shifter's color_string.
//  The shadow buffer fills while the active frame stays stable; a complete frame is committed
//  atomically, so led_shifter never sees a partially written frame.
// PARAMETERS
//  N_LEDS       6      number of LEDs in the chain; frame = 3*N_LEDS bytes
//  TIMEOUT_CYC  48000  idle clocks allowed between bytes inside a frame before abort (1 ms @ 48 MHz)
// PORTS
//  clk           in   1          system clock; single clock domain
//  rst           in   1          asynchronous, active-high reset
//  sof           in   1          start-of-frame pulse, 1 cycle, already synchronised to clk
//  byte_valid    in   1          byte_data valid this cycle
//  byte_data     in   8          payload byte
//  byte_ready    out  1          loader accepts byte_data when byte_valid & byte_ready
//  color_string  out  24*N_LEDS  active frame to led_shifter; LED0 in MSBs [24*N_LEDS-1 -: 24]
//  frame_update  out  1          1-cycle pulse: color_string took a new frame this cycle
//  frame_err     out  1          1-cycle pulse: frame aborted (restart or timeout)
//  busy          out  1          high while in LOAD or COMMIT
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, idx=0, timeout cnt=0, shadow=0, color_string=0 (all off),
//   frame_update=0, frame_err=0, byte_ready=1, busy=0. Reset mid-frame discards the partial frame.
//  FSM states IDLE, LOAD, COMMIT (byte_ready = 1 in IDLE/LOAD, 0 in COMMIT; busy = LOAD|COMMIT):
//   IDLE: bytes ignored (no write, no error). sof -> LOAD with idx=0, cnt=0.
//   LOAD: accepted byte written to shadow byte idx; byte k of the frame lands at bits
//    [24*N_LEDS-1-8k -: 8] (MSB-first, 3 bytes per LED in stream order). idx++, cnt=0.
//    Accepting byte idx = 3*N_LEDS-1 -> COMMIT.
//    No accepted byte: cnt++; cnt reaching TIMEOUT_CYC-1 with no byte -> IDLE, frame_err pulse.
//    sof in LOAD (idx>0) -> stay in LOAD, idx=0, cnt=0, frame_err pulse; sof at idx=0 is a
//    clean restart with no error.
//   COMMIT: one cycle; on the edge leaving it, color_string <= shadow, frame_update <= 1,
//    state -> IDLE. sof during COMMIT is ignored (commit completes).
//  Simultaneous sof and byte_valid: sof wins; the coincident byte is dropped (not written, not
//   counted), in both IDLE and LOAD.
//  Latency: last byte accepted at edge E -> COMMIT during E..E+1; color_string new and
//   frame_update=1 in the cycle after E+1. Next sof is accepted from that cycle onward.
//  Aborted/partial frames never modify color_string; shadow is not cleared on abort (its old
//   contents are overwritten by the next frame before any commit).
//  idx width $clog2(3*N_LEDS); cnt width $clog2(TIMEOUT_CYC+1); cnt saturates, never wraps.
//  frame_update and frame_err are registered, never both high in the same cycle.
// TESTING
//  1 rst=1 25 ns -> color_string=0, byte_ready=1, busy=0, frame_update=frame_err=0.
//  2 sof, then 18 bytes 00 CE FF x3, 7F 32 A8 x3 -> exactly one frame_update pulse
//    2 cycles after last byte edge; color_string={24'h00CEFF x3, 24'h7F32A8 x3}; busy low after.
//  3 In IDLE, 6 bytes with no sof -> no write, no pulse; color_string unchanged.
//  4 sof, 10 bytes, sof, full 18-byte frame -> frame_err pulse at 2nd sof; only 2nd frame
//    committed; one frame_update.
//  5 TIMEOUT_CYC=16: sof, 5 bytes, idle -> frame_err pulse 16 cycles after last byte;
//    state IDLE, color_string unchanged; sof+byte_valid same cycle -> byte dropped.
//  6 After a committed frame, sof, 9 bytes, assert rst -> color_string=0, IDLE, busy=0 at once.

Source files
------------

// File: rtl/led_frame_loader_if.sv
// Byte-stream link from the MCU SPI receiver into the LED frame loader.
interface led_frame_loader_if;
  // Handshake: a byte transfers on a rising clk edge where byte_valid and
  // byte_ready are both high. sof is a 1-cycle pulse and needs no ready.
  logic       sof;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output sof, output byte_valid, output byte_data, input byte_ready);
  modport slave  (input sof, input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/led_frame_loader.sv
// Double-buffered frame assembler: bytes fill a shadow frame, and only a
// complete frame is copied to color_string for led_shifter.
module led_frame_loader #(
  parameter int N_LEDS      = 6,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_frame_loader_if.slave    bus,
  output logic [24*N_LEDS-1:0] color_string,
  output logic                 frame_update,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           state_dbg
);
  localparam int N_BYTES = 3 * N_LEDS;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [N_BYTES-1:0][7:0] shadow;
  logic                    wr_en, err_n, upd_n, accept;

  assign bus.byte_ready = (state != S_COMMIT);
  assign busy           = (state != S_IDLE);
  assign state_dbg      = state;
  assign accept         = bus.byte_valid & bus.byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      color_string <= '0;
      frame_update <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      frame_update <= upd_n;
      frame_err    <= err_n;
      // Stream byte k lands in packed slot N_BYTES-1-k, i.e. MSB-first.
      if (wr_en) shadow[LAST_IDX - idx] <= bus.byte_data;
      if (upd_n) color_string <= shadow;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    err_n   = 1'b0;
    upd_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.sof) begin
          state_n = S_LOAD;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        // sof outranks a coincident byte, which is dropped.
        if (bus.sof) begin
          idx_n = '0;
          cnt_n = '0;
          err_n = (idx != '0);
        end else if (accept) begin
          wr_en = 1'b1;
          cnt_n = '0;
          if (idx == LAST_IDX) begin
            state_n = S_COMMIT;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else if (cnt == CNT_LIMIT) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_COMMIT: begin
        state_n = S_IDLE;
        upd_n   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
